// File: rtl/pwm_audio_capture.sv
// Recovers WIDTH-bit PCM samples from a 1-bit PWM line by counting high cycles over 2^WIDTH-cycle windows.
// Optional majority deglitch filter after the synchronizer: define PWM_AUDIO_CAPTURE_DEGLITCH_EN.
module pwm_audio_capture #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             pwm_in,
    input  logic             clear_overrun,
    input  logic             sample_rdy,
    output logic [WIDTH-1:0] sample,
    output logic             sample_vld,
    output logic             overrun
);

    localparam logic [WIDTH-1:0] WCNT_LAST = '1;
    localparam logic [WIDTH:0]   SAT_MAX   = {1'b0, {WIDTH{1'b1}}};

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_s;
    logic                   cnt_bit;

    logic [WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WIDTH:0]   hcnt_q, hcnt_d;
    logic [WIDTH:0]   hsum;
    logic [WIDTH-1:0] total;
    logic             win_done;

    logic [WIDTH-1:0] sample_q, sample_d;
    logic             sample_vld_q, sample_vld_d;
    logic             overrun_q, overrun_d;
    logic             xfer;
    logic             ovr_set;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pwm_in};
        pwm_s  = sync_q[SYNC_STAGES-1];
    end

`ifdef PWM_AUDIO_CAPTURE_DEGLITCH_EN
    // Majority of three consecutive bits; its centre tap gives exactly one cycle of delay.
    logic [1:0] tap_q, tap_d;

    always_comb begin
        tap_d   = {tap_q[0], pwm_s};
        cnt_bit = (pwm_s & tap_q[0]) | (pwm_s & tap_q[1]) | (tap_q[0] & tap_q[1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_q <= '0;
        end else begin
            tap_q <= tap_d;
        end
    end
`else
    always_comb begin
        cnt_bit = pwm_s;
    end
`endif

    always_comb begin
        hsum     = hcnt_q + {{WIDTH{1'b0}}, cnt_bit};
        total    = (hsum > SAT_MAX) ? WCNT_LAST : hsum[WIDTH-1:0];
        wcnt_d   = wcnt_q;
        hcnt_d   = hcnt_q;
        win_done = 1'b0;
        if (ena) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == WCNT_LAST) begin
                win_done = 1'b1;
                hcnt_d   = '0;
            end else begin
                hcnt_d = hsum;
            end
        end
    end

    // A finished window is dropped only when the held sample is not leaving this cycle.
    always_comb begin
        xfer         = sample_vld_q & sample_rdy;
        sample_d     = sample_q;
        sample_vld_d = sample_vld_q;
        ovr_set      = 1'b0;
        if (win_done) begin
            if (!sample_vld_q || xfer) begin
                sample_d     = total;
                sample_vld_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (xfer) begin
            sample_vld_d = 1'b0;
        end
        overrun_d = ovr_set | (overrun_q & ~clear_overrun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            wcnt_q       <= '0;
            hcnt_q       <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            wcnt_q       <= wcnt_d;
            hcnt_q       <= hcnt_d;
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
            overrun_q    <= overrun_d;
        end
    end

    assign sample     = sample_q;
    assign sample_vld = sample_vld_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_audio_capture.sv
// Directed bench for pwm_audio_capture: encoder-driven windows, saturation, backpressure, reset, enable, glitches.
module tb_pwm_audio_capture;

    localparam int SYNC = 2;
`ifdef PWM_AUDIO_CAPTURE_DEGLITCH_EN
    localparam int DLY        = SYNC + 1;
    localparam int GLITCH_EXP = 0;
`else
    localparam int DLY        = SYNC;
    localparam int GLITCH_EXP = 15;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       pwm_in;
    logic       clear_overrun;
    logic       sample_rdy;
    logic [7:0] sample;
    logic       sample_vld;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // Line source: mode 0 = PWM encoder, 1 = constant, 2 = one-cycle pulse every 17 cycles
    int          mode       = 1;
    int          const_val  = 0;
    int          enc_sample = 0;
    int unsigned load_pos   = 0;
    int          load_seq   = 0;

    pwm_audio_capture #(.WIDTH(8), .SYNC_STAGES(SYNC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .pwm_in        (pwm_in),
        .clear_overrun (clear_overrun),
        .sample_rdy    (sample_rdy),
        .sample        (sample),
        .sample_vld    (sample_vld),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    // Line changes 2 time units after each rising edge; a position reload takes effect on the next update.
    initial begin
        int unsigned pos;
        int          seen_seq;
        pos      = 0;
        seen_seq = 0;
        pwm_in   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (load_seq != seen_seq) begin
                pos      = load_pos;
                seen_seq = load_seq;
            end
            case (mode)
                0:       pwm_in = ((pos % 256) < enc_sample);
                1:       pwm_in = (const_val != 0);
                default: pwm_in = ((pos % 17) == 0);
            endcase
            pos++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_vld(input string name, output int n);
        bit found;
        found = 1'b0;
        n     = 0;
        for (int i = 1; i <= 700 && !found; i++) begin
            @(negedge clk);
            n = i;
            if (sample_vld) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL %s: sample_vld not seen within 700 cycles", name);
        end
    endtask

    // Returns at a window boundary; from then on bit k counted after it equals source position k.
    task automatic align(input int m, input int val);
        int n;
        wait_vld("align", n);
        mode = m;
        if (m == 0) enc_sample = val;
        else        const_val  = val;
        load_pos = DLY + 2;
        load_seq++;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        ena           = 1'b1;
        clear_overrun = 1'b0;
        sample_rdy    = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (sample !== 8'd0)     begin bad++; $display("FAIL reset_sample: got %0d expected 0", sample); end
        total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b expected 0", sample_vld); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        rst_n = 1'b1;
    endtask

    task automatic test_encoder_128();
        int n;
        align(0, 128);
        wait_vld("enc128_skip", n);
        wait_vld("enc128_w1", n);
        total++; if (sample !== 8'd128) begin bad++; $display("FAIL enc128_w1: got %0d expected 128", sample); end
        total++; if (n != 256)          begin bad++; $display("FAIL enc128_period1: got %0d expected 256", n); end
        @(negedge clk);
        total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL enc128_pulse: vld got %b expected 0", sample_vld); end
        wait_vld("enc128_w2", n);
        total++; if (sample !== 8'd128) begin bad++; $display("FAIL enc128_w2: got %0d expected 128", sample); end
        total++; if (n != 255)          begin bad++; $display("FAIL enc128_period2: got %0d expected 255", n); end
    endtask

    task automatic test_constant();
        int n;
        align(1, 0);
        wait_vld("const0_skip", n);
        wait_vld("const0", n);
        total++; if (sample !== 8'd0) begin bad++; $display("FAIL const0: got %0d expected 0", sample); end
        align(1, 1);
        wait_vld("const1_skip", n);
        wait_vld("const1", n);
        total++; if (sample !== 8'd255) begin bad++; $display("FAIL const1_sat: got %0d expected 255", sample); end
        total++; if (overrun !== 1'b0)  begin bad++; $display("FAIL const1_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_backpressure();
        int n;
        align(0, 37);
        wait_vld("bp_skip", n);
        wait_vld("bp_sync", n);
        @(negedge clk);
        sample_rdy = 1'b0;
        repeat (255) @(negedge clk);
        total++; if (sample_vld !== 1'b1) begin bad++; $display("FAIL bp_w1_vld: got %b expected 1", sample_vld); end
        total++; if (sample !== 8'd37)    begin bad++; $display("FAIL bp_w1_sample: got %0d expected 37", sample); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL bp_w1_overrun: got %b expected 0", overrun); end
        // Swap the duty so a wrongly loaded later window would show up in the held sample.
        enc_sample = 90;
        repeat (256) @(negedge clk);
        total++; if (overrun !== 1'b1)    begin bad++; $display("FAIL bp_w2_overrun: got %b expected 1", overrun); end
        total++; if (sample !== 8'd37)    begin bad++; $display("FAIL bp_w2_sample: got %0d expected 37", sample); end
        repeat (255) @(negedge clk);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        total++; if (overrun !== 1'b1)    begin bad++; $display("FAIL bp_set_wins: got %b expected 1", overrun); end
        total++; if (sample !== 8'd37)    begin bad++; $display("FAIL bp_w3_sample: got %0d expected 37", sample); end
        repeat (2) @(negedge clk);
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL bp_clear: got %b expected 0", overrun); end
        sample_rdy = 1'b1;
        @(negedge clk);
        total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL bp_drain: vld got %b expected 0", sample_vld); end
    endtask

    task automatic test_reset_mid();
        int n;
        align(1, 1);
        wait_vld("rst_skip", n);
        wait_vld("rst_sync", n);
        sample_rdy = 1'b0;
        repeat (100) @(negedge clk);
        total++; if (sample !== 8'd255) begin bad++; $display("FAIL rst_pre_sample: got %0d expected 255", sample); end
        rst_n = 1'b0;
        #1;
        total++; if (sample !== 8'd0)     begin bad++; $display("FAIL rst_mid_sample: got %0d expected 0", sample); end
        total++; if (sample_vld !== 1'b0) begin bad++; $display("FAIL rst_mid_vld: got %b expected 0", sample_vld); end
        total++; if (overrun !== 1'b0)    begin bad++; $display("FAIL rst_mid_overrun: got %b expected 0", overrun); end
        mode       = 0;
        enc_sample = 64;
        load_pos   = 128;
        load_seq++;
        repeat (10) @(negedge clk);
        rst_n      = 1'b1;
        sample_rdy = 1'b1;
        wait_vld("rst_first", n);
        total++; if (n != 256)         begin bad++; $display("FAIL rst_first_latency: got %0d expected 256", n); end
        total++; if (sample !== 8'd64) begin bad++; $display("FAIL rst_first_sample: got %0d expected 64", sample); end
    endtask

    task automatic test_ena();
        int n;
        align(0, 200);
        wait_vld("ena_skip", n);
        wait_vld("ena_sync", n);
        repeat (100) @(negedge clk);
        ena = 1'b0;
        repeat (50) @(negedge clk);
        ena = 1'b1;
        wait_vld("ena_win", n);
        total++; if (n != 156)          begin bad++; $display("FAIL ena_stretch: got %0d expected 156", n); end
        total++; if (sample !== 8'd200) begin bad++; $display("FAIL ena_sample: got %0d expected 200", sample); end
    endtask

    task automatic test_glitch();
        int n;
        align(2, 0);
        wait_vld("glitch_skip", n);
        wait_vld("glitch", n);
        total++;
        if (sample !== 8'(GLITCH_EXP)) begin
            bad++;
            $display("FAIL glitch: got %0d expected %0d", sample, GLITCH_EXP);
        end
    endtask

    initial begin
        test_reset();
        test_encoder_128();
        test_constant();
        test_backpressure();
        test_reset_mid();
        test_ena();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
